load_store_responder: RTL
=========================

# load_store_responder

Memory-side responder for the load/store request port. Accepts one request at a time from the load/store pipe arbiter and issues it as a word-aligned, big-endian bus access to the memory/MMU port. Returns load data, MMU flags and a one-cycle valid pulse to the arbiter, which steers them to the execute stage or to the exception unit.

## Interface
- No parameters.
- iCLOCK  in  1  clock
- inRESET  in  1  asynchronous active-low reset
- iLDST_REQ  in  1  request strobe from arbiter
- oLDST_BUSY  out  1  responder cannot accept a request
- iLDST_ORDER  in  2  0 = byte, 1 = halfword, 2 = word, 3 = reserved (treated as word)
- iLDST_MASK  in  4  byte-enable qualifier (4'hf on exception path)
- iLDST_RW  in  1  1 = store, 0 = load
- iLDST_ASID  in  14  address-space ID
- iLDST_MMUMOD  in  2  MMU mode
- iLDST_MMUPS  in  3  page size
- iLDST_PDT  in  32  page directory base
- iLDST_ADDR  in  32  byte address
- iLDST_DATA  in  32  store data, right-justified
- oLDST_VALID  out  1  one-cycle response pulse
- oLDST_MMU_FLAGS  out  12  [0] misaligned, [1] timeout, [11:2] iMEM_MMU_FLAGS
- oLDST_DATA  out  32  load data, zero-extended, right-justified
- oMEM_REQ  out  1  bus request
- iMEM_LOCK  in  1  bus stall; request is accepted on a cycle with oMEM_REQ=1 and iMEM_LOCK=0
- oMEM_RW, oMEM_ADDR[31:0], oMEM_MASK[3:0], oMEM_DATA[31:0]  out  bus command, word address (ADDR[1:0]=0), lane mask, lane-aligned data
- oMEM_ASID[13:0], oMEM_MMUMOD[1:0], oMEM_MMUPS[2:0], oMEM_PDT[31:0]  out  latched MMU context
- iMEM_VALID  in  1  bus response
- iMEM_DATA  in  32  read word
- iMEM_MMU_FLAGS  in  10  MMU status

## Operation
- FSM: IDLE, REQ, WAIT, FAULT. oLDST_BUSY = (state != IDLE).
- IDLE: on iLDST_REQ, latch all request fields. Misaligned requests (halfword with ADDR[0]=1, word with ADDR[1:0]!=0) go to FAULT; all others go to REQ.
- REQ: oMEM_REQ=1 and all oMEM_* stable. When iMEM_LOCK=0, go to WAIT.
- WAIT: on iMEM_VALID, register the response and go to IDLE.
- FAULT: issues no bus access. Drives the response with flags[0]=1 and data 0, then goes to IDLE.
- Lane mask (big-endian, lane 0 = bits [31:24]):
  - Byte: 4'b1000 >> ADDR[1:0].
  - Halfword: 4'b1100 >> ADDR[1:0].
  - Word: 4'b1111.
  - oMEM_MASK = lane mask & iLDST_MASK.
- Store data: DATA[7:0] or DATA[15:0] is placed at the selected lanes; unselected lanes are 0.
- Load data: the selected lanes are extracted, shifted down and zero-extended. oLDST_MMU_FLAGS[11:2] = iMEM_MMU_FLAGS.
- Response fields hold their value until the next response. oLDST_VALID is high for exactly one cycle.
- Reset values: state IDLE; oLDST_BUSY 0; oLDST_VALID 0; oLDST_DATA 0; oLDST_MMU_FLAGS 0; oMEM_REQ 0; all other oMEM_* 0.

## Timing
- Request accepted in cycle N (IDLE, iLDST_REQ=1). oMEM_REQ is high from N+1.
- With iMEM_LOCK=0 in N+1 and iMEM_VALID in N+2, oLDST_VALID is high in N+3.
- Misaligned request: oLDST_VALID in N+2.
- oLDST_VALID coincides with state=IDLE, so a new request is accepted in the response cycle (back-to-back operation).
- iMEM_VALID outside WAIT is ignored. iLDST_REQ while busy is ignored; the arbiter must hold it.
- Reset mid-transaction: immediate return to IDLE. No response is produced, and oMEM_REQ drops asynchronously.

## Configuration
- LDST_RESPONDER_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to WAIT and increments each cycle in WAIT.
  - If the count reaches 255 with no iMEM_VALID, the block responds with flags[1]=1, flags[11:2]=0 and data 0, then goes to IDLE.
  - iMEM_VALID in the same cycle as count 255 wins.
- LDST_RESPONDER_TIMEOUT_EN undefined: no counter; WAIT lasts until iMEM_VALID. Flags bit [1] is always 0.

## Test plan
- Word load, ADDR=0x1000, iMEM_DATA=0xDEADBEEF, no lock -> oMEM_ADDR=0x1000, MASK=4'hf; oLDST_VALID 3 cycles after accept; oLDST_DATA=0xDEADBEEF.
- Byte store, ADDR=0x2003, DATA=0x000000A5, iLDST_MASK=4'hf -> oMEM_ADDR=0x2000, MASK=4'b0001, oMEM_DATA=0x000000A5.
- Halfword load, ADDR=0x3002, iMEM_DATA=0x1234ABCD, iMEM_LOCK held 4 cycles -> oMEM_REQ stays high 5 cycles; oLDST_DATA=0x0000ABCD.
- Word load at ADDR=0x4001 -> no oMEM_REQ; oLDST_VALID 2 cycles after accept; flags=12'h001; data 0.
- Back-to-back: second iLDST_REQ presented in the first response cycle -> accepted in that cycle; its oMEM_REQ rises the next cycle.
- With LDST_RESPONDER_TIMEOUT_EN, no iMEM_VALID -> oLDST_VALID 256 cycles after WAIT entry with flags=12'h002. Reset asserted in WAIT -> all outputs 0, no response afterward.

Source files
------------

// File: rtl/load_store_responder.sv
// load_store_responder: memory-side responder for the load/store port.
// Optional response timeout: define LDST_RESPONDER_TIMEOUT_EN.
module load_store_responder (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iLDST_REQ,
  output logic        oLDST_BUSY,
  input  logic [1:0]  iLDST_ORDER,
  input  logic [3:0]  iLDST_MASK,
  input  logic        iLDST_RW,
  input  logic [13:0] iLDST_ASID,
  input  logic [1:0]  iLDST_MMUMOD,
  input  logic [2:0]  iLDST_MMUPS,
  input  logic [31:0] iLDST_PDT,
  input  logic [31:0] iLDST_ADDR,
  input  logic [31:0] iLDST_DATA,
  output logic        oLDST_VALID,
  output logic [11:0] oLDST_MMU_FLAGS,
  output logic [31:0] oLDST_DATA,
  output logic        oMEM_REQ,
  input  logic        iMEM_LOCK,
  output logic        oMEM_RW,
  output logic [31:0] oMEM_ADDR,
  output logic [3:0]  oMEM_MASK,
  output logic [31:0] oMEM_DATA,
  output logic [13:0] oMEM_ASID,
  output logic [1:0]  oMEM_MMUMOD,
  output logic [2:0]  oMEM_MMUPS,
  output logic [31:0] oMEM_PDT,
  input  logic        iMEM_VALID,
  input  logic [31:0] iMEM_DATA,
  input  logic [9:0]  iMEM_MMU_FLAGS
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FAULT
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic        accept;
  logic        rsp_ok;
  logic        rsp_fault;
  logic        rsp_to;
  logic        to_hit;

  logic [1:0]  r_order;
  logic [1:0]  r_lsb;

  logic [3:0]  lane;
  logic [31:0] wdata;
  logic        misalign;
  logic [4:0]  wsh;

  logic [4:0]  rsh;
  logic [31:0] rshift;
  logic [31:0] ld;

  // Lane mask, lane-aligned store data and alignment check of the request
  always_comb begin
    lane     = 4'b1111;
    wdata    = iLDST_DATA;
    misalign = 1'b0;
    wsh      = '0;
    unique case (1'b1)
      (iLDST_ORDER == 2'd0): begin
        lane  = 4'b1000 >> iLDST_ADDR[1:0];
        wsh   = {~iLDST_ADDR[1:0], 3'b000};
        wdata = {24'b0, iLDST_DATA[7:0]} << wsh;
      end
      (iLDST_ORDER == 2'd1): begin
        lane     = 4'b1100 >> iLDST_ADDR[1:0];
        wsh      = {~iLDST_ADDR[1], 4'b0000};
        wdata    = {16'b0, iLDST_DATA[15:0]} << wsh;
        misalign = iLDST_ADDR[0];
      end
      default: begin
        misalign = |iLDST_ADDR[1:0];
      end
    endcase
  end

  // Extract the selected lanes of the read word, right-justified
  always_comb begin
    rsh    = '0;
    rshift = iMEM_DATA;
    ld     = iMEM_DATA;
    unique case (1'b1)
      (r_order == 2'd0): begin
        rsh    = {~r_lsb, 3'b000};
        rshift = iMEM_DATA >> rsh;
        ld     = {24'b0, rshift[7:0]};
      end
      (r_order == 2'd1): begin
        rsh    = {~r_lsb[1], 4'b0000};
        rshift = iMEM_DATA >> rsh;
        ld     = {16'b0, rshift[15:0]};
      end
      default: begin
        ld = iMEM_DATA;
      end
    endcase
  end

`ifdef LDST_RESPONDER_TIMEOUT_EN
  logic [7:0] to_cnt;

  // Cycles spent waiting for the bus response
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      to_cnt <= '0;
    end else if (state != S_WAIT) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 8'd1;
    end
  end

  assign to_hit = (to_cnt == 8'hff);
`else
  assign to_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and handshake strobes
  always_comb begin
    state_nx   = state;
    accept     = 1'b0;
    rsp_ok     = 1'b0;
    rsp_fault  = 1'b0;
    rsp_to     = 1'b0;
    oMEM_REQ   = 1'b0;
    oLDST_BUSY = (state != S_IDLE);
    unique case (state)
      S_IDLE: begin
        if (iLDST_REQ) begin
          accept   = 1'b1;
          state_nx = misalign ? S_FAULT : S_REQ;
        end
      end
      S_REQ: begin
        oMEM_REQ = 1'b1;
        if (!iMEM_LOCK) begin
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (iMEM_VALID) begin
          rsp_ok   = 1'b1;
          state_nx = S_IDLE;
        end else if (to_hit) begin
          rsp_to   = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_FAULT: begin
        rsp_fault = 1'b1;
        state_nx  = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Latch the bus command and MMU context at accept
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      oMEM_RW     <= 1'b0;
      oMEM_ADDR   <= '0;
      oMEM_MASK   <= '0;
      oMEM_DATA   <= '0;
      oMEM_ASID   <= '0;
      oMEM_MMUMOD <= '0;
      oMEM_MMUPS  <= '0;
      oMEM_PDT    <= '0;
      r_order     <= '0;
      r_lsb       <= '0;
    end else if (accept) begin
      oMEM_RW     <= iLDST_RW;
      oMEM_ADDR   <= {iLDST_ADDR[31:2], 2'b00};
      oMEM_MASK   <= lane & iLDST_MASK;
      oMEM_DATA   <= wdata;
      oMEM_ASID   <= iLDST_ASID;
      oMEM_MMUMOD <= iLDST_MMUMOD;
      oMEM_MMUPS  <= iLDST_MMUPS;
      oMEM_PDT    <= iLDST_PDT;
      r_order     <= iLDST_ORDER;
      r_lsb       <= iLDST_ADDR[1:0];
    end
  end

  // Response pulse; data and flags hold until the next response
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      oLDST_VALID     <= 1'b0;
      oLDST_DATA      <= '0;
      oLDST_MMU_FLAGS <= '0;
    end else begin
      oLDST_VALID <= rsp_ok | rsp_fault | rsp_to;
      if (rsp_ok) begin
        oLDST_DATA      <= ld;
        oLDST_MMU_FLAGS <= {iMEM_MMU_FLAGS, 2'b00};
      end else if (rsp_fault) begin
        oLDST_DATA      <= '0;
        oLDST_MMU_FLAGS <= 12'h001;
      end else if (rsp_to) begin
        oLDST_DATA      <= '0;
        oLDST_MMU_FLAGS <= 12'h002;
      end
    end
  end

endmodule
